// File: rtl/btle_scan_pkg.sv
// Shared constants, state encoding and helpers for the BLE advertising-channel scan controller.
package btle_scan_pkg;

  localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;
  localparam logic [23:0] ADV_CRC_INIT    = 24'h555555;
  localparam int          ADV_CH_FIRST    = 37;
  localparam int          ADV_CH_LAST     = 39;
  localparam int          MAX_PDU_OCTETS  = 64;

  typedef enum logic [2:0] {
    IDLE,
    HOP,
    LISTEN,
    RECEIVE,
    DRAIN
  } scan_state_e;

  // Header (2 octets) plus payload, clipped to the receiver's octet memory depth.
  function automatic logic [6:0] pdu_octet_count(input logic [6:0] payload_length);
    if (payload_length >= 7'(MAX_PDU_OCTETS - 2)) begin
      return 7'(MAX_PDU_OCTETS);
    end
    return payload_length + 7'd2;
  endfunction

endpackage

// File: rtl/btle_pdu_drain.sv
// Reads N octets out of the receiver's PDU memory (1-cycle read latency after the
// registered address) and presents them on a valid/ready stream, one octet per 2 cycles.
module btle_pdu_drain #(
  parameter int CH_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [6:0]      n_octets_i,
  input  logic            crc_ok_i,
  input  logic [CH_W-1:0] channel_i,
  output logic [5:0]      mem_addr_o,
  input  logic [7:0]      mem_data_i,
  output logic [7:0]      pkt_data_o,
  output logic            pkt_valid_o,
  input  logic            pkt_ready_i,
  output logic            pkt_last_o,
  output logic [CH_W-1:0] pkt_channel_o,
  output logic            pkt_crc_ok_o,
  output logic            done_o
);

  logic [5:0]      addr_q, addr_d;
  logic            fetch_q, fetch_d;
  logic [6:0]      n_q, n_d;
  logic            crc_q, crc_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [CH_W-1:0] pch_q, pch_d;
  logic            pcrc_q, pcrc_d;
  logic            handshake;

  assign handshake = valid_q && pkt_ready_i;
  assign done_o    = handshake && last_q;

  always_comb begin
    addr_d  = addr_q;
    fetch_d = fetch_q;
    n_d     = n_q;
    crc_d   = crc_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    pch_d   = pch_q;
    pcrc_d  = pcrc_q;
    if (start_i) begin
      addr_d  = 6'd0;
      fetch_d = 1'b1;
      n_d     = n_octets_i;
      crc_d   = crc_ok_i;
      ch_d    = channel_i;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (fetch_q) begin
      // Address has been stable for a cycle, so the memory output is now valid.
      fetch_d = 1'b0;
      data_d  = mem_data_i;
      valid_d = 1'b1;
      last_d  = ({1'b0, addr_q} == (n_q - 7'd1));
      pch_d   = ch_q;
      pcrc_d  = crc_q;
    end else if (handshake) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (!last_q) begin
        addr_d  = addr_q + 6'd1;
        fetch_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 6'd0;
      fetch_q <= 1'b0;
      n_q     <= 7'd0;
      crc_q   <= 1'b0;
      ch_q    <= '0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pch_q   <= '0;
      pcrc_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      n_q     <= n_d;
      crc_q   <= crc_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pch_q   <= pch_d;
      pcrc_q  <= pcrc_d;
    end
  end

  assign mem_addr_o    = addr_q;
  assign pkt_data_o    = data_q;
  assign pkt_valid_o   = valid_q;
  assign pkt_last_o    = last_q;
  assign pkt_channel_o = pch_q;
  assign pkt_crc_ok_o  = pcrc_q;

endmodule

// File: rtl/btle_rx_scan_ctrl.sv
// Scan controller: hops btle_rx over advertising channels 37/38/39 and streams decoded PDUs.
// Define BTLE_RX_SCAN_CRC_DROP_EN to discard packets that fail CRC instead of draining them.
module btle_rx_scan_ctrl
  import btle_scan_pkg::*;
#(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
  parameter int CRC_STATE_BIT_WIDTH      = 24,
  parameter int DWELL_BIT_WIDTH          = 24,
  parameter int RX_TIMEOUT_SAMPLES       = 20000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stop,
  input  logic [DWELL_BIT_WIDTH-1:0]          dwell_samples,
  input  logic                                iq_valid,
  input  logic                                rx_hit_flag,
  input  logic                                rx_decode_end,
  input  logic                                rx_crc_ok,
  input  logic [6:0]                          rx_payload_length,
  input  logic [7:0]                          rx_pdu_octet_mem_data,
  output logic [5:0]                          rx_pdu_octet_mem_addr,
  output logic                                rx_rst,
  output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
  output logic [7:0]                          pkt_data,
  output logic                                pkt_valid,
  input  logic                                pkt_ready,
  output logic                                pkt_last,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] pkt_channel,
  output logic                                pkt_crc_ok,
  output logic                                busy
);

  localparam int CW    = CHANNEL_NUMBER_BIT_WIDTH;
  localparam int TMO_W = $clog2(RX_TIMEOUT_SAMPLES + 1);
  localparam logic [CW-1:0]    CH_FIRST = CW'(ADV_CH_FIRST);
  localparam logic [CW-1:0]    CH_LAST  = CW'(ADV_CH_LAST);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RX_TIMEOUT_SAMPLES - 1);

  scan_state_e                state_q, state_d;
  logic [CW-1:0]              channel_q, channel_d, channel_next;
  logic                       rx_rst_q, rx_rst_d;
  logic                       busy_q, busy_d;
  logic [DWELL_BIT_WIDTH-1:0] dwell_q, dwell_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic                       stop_pend_q, stop_pend_d;
  logic                       drain_start;
  logic                       drain_done;

  assign channel_next = (channel_q == CH_LAST) ? CH_FIRST : channel_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    channel_d   = channel_q;
    rx_rst_d    = 1'b0;
    dwell_d     = dwell_q;
    tmo_d       = tmo_q;
    stop_pend_d = stop_pend_q;
    drain_start = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d   = HOP;
          channel_d = CH_FIRST;
        end
      end
      HOP: begin
        dwell_d = '0;
        state_d = stop ? IDLE : LISTEN;
        rx_rst_d = stop;
      end
      LISTEN: begin
        if (stop) begin
          state_d  = IDLE;
          rx_rst_d = 1'b1;
        end else if (rx_hit_flag) begin
          state_d = RECEIVE;
          tmo_d   = '0;
        end else if (iq_valid) begin
          dwell_d = dwell_q + DWELL_BIT_WIDTH'(1);
          if ((dwell_samples != '0) && (dwell_q == dwell_samples - DWELL_BIT_WIDTH'(1))) begin
            state_d   = HOP;
            channel_d = channel_next;
          end
        end
      end
      RECEIVE: begin
        if (stop) begin
          state_d  = IDLE;
          rx_rst_d = 1'b1;
        end else if (rx_decode_end) begin
`ifdef BTLE_RX_SCAN_CRC_DROP_EN
          if (!rx_crc_ok) begin
            state_d   = HOP;
            channel_d = channel_next;
          end else begin
            state_d     = DRAIN;
            drain_start = 1'b1;
          end
`else
          state_d     = DRAIN;
          drain_start = 1'b1;
`endif
        end else if (iq_valid) begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            state_d   = HOP;
            channel_d = channel_next;
          end
        end
      end
      DRAIN: begin
        // A stop here must not truncate the packet; remember it for the end of the drain.
        if (stop) stop_pend_d = 1'b1;
        if (drain_done) begin
          stop_pend_d = 1'b0;
          if (stop_pend_q || stop) begin
            state_d = IDLE;
          end else begin
            state_d   = HOP;
            channel_d = channel_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == HOP) rx_rst_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      channel_q   <= CH_FIRST;
      rx_rst_q    <= 1'b0;
      busy_q      <= 1'b0;
      dwell_q     <= '0;
      tmo_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      channel_q   <= channel_d;
      rx_rst_q    <= rx_rst_d;
      busy_q      <= busy_d;
      dwell_q     <= dwell_d;
      tmo_q       <= tmo_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  btle_pdu_drain #(
    .CH_W(CW)
  ) u_drain (
    .clk          (clk),
    .rst          (rst),
    .start_i      (drain_start),
    .n_octets_i   (pdu_octet_count(rx_payload_length)),
    .crc_ok_i     (rx_crc_ok),
    .channel_i    (channel_q),
    .mem_addr_o   (rx_pdu_octet_mem_addr),
    .mem_data_i   (rx_pdu_octet_mem_data),
    .pkt_data_o   (pkt_data),
    .pkt_valid_o  (pkt_valid),
    .pkt_ready_i  (pkt_ready),
    .pkt_last_o   (pkt_last),
    .pkt_channel_o(pkt_channel),
    .pkt_crc_ok_o (pkt_crc_ok),
    .done_o       (drain_done)
  );

  assign rx_rst              = rx_rst_q;
  assign busy                = busy_q;
  assign channel_number      = channel_q;
  assign unique_bit_sequence = LEN_UNIQUE_BIT_SEQUENCE'(ADV_ACCESS_ADDR);
  assign crc_state_init_bit  = CRC_STATE_BIT_WIDTH'(ADV_CRC_INIT);

endmodule

// File: tb/tb_btle_rx_scan_ctrl.sv
// Directed bench for btle_rx_scan_ctrl: channel hopping, packet drain table, stop/timeout/reset corners.
module tb_btle_rx_scan_ctrl;

  localparam int TMO = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [23:0] dwell_samples = 24'd0;
  logic        iq_valid = 1'b0, rx_hit_flag = 1'b0, rx_decode_end = 1'b0, rx_crc_ok = 1'b0;
  logic [6:0]  rx_payload_length = 7'd0;
  logic [7:0]  rx_pdu_octet_mem_data;
  logic [5:0]  rx_pdu_octet_mem_addr;
  logic        rx_rst;
  logic [31:0] unique_bit_sequence;
  logic [5:0]  channel_number, pkt_channel;
  logic [23:0] crc_state_init_bit;
  logic [7:0]  pkt_data;
  logic        pkt_valid, pkt_last, pkt_crc_ok, busy;
  logic        pkt_ready = 1'b0;

  logic [7:0] mem [64];
  assign rx_pdu_octet_mem_data = mem[rx_pdu_octet_mem_addr];

  always #5 clk = ~clk;

  btle_rx_scan_ctrl #(.RX_TIMEOUT_SAMPLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell_samples(dwell_samples),
    .iq_valid(iq_valid), .rx_hit_flag(rx_hit_flag), .rx_decode_end(rx_decode_end),
    .rx_crc_ok(rx_crc_ok), .rx_payload_length(rx_payload_length),
    .rx_pdu_octet_mem_data(rx_pdu_octet_mem_data), .rx_pdu_octet_mem_addr(rx_pdu_octet_mem_addr),
    .rx_rst(rx_rst), .unique_bit_sequence(unique_bit_sequence), .channel_number(channel_number),
    .crc_state_init_bit(crc_state_init_bit), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_last(pkt_last), .pkt_channel(pkt_channel),
    .pkt_crc_ok(pkt_crc_ok), .busy(busy)
  );

  typedef struct {
    int len; bit crc; int stall_idx; int stall_cyc; int stop_idx;
    int exp_ch; int exp_n; bit exp_crc; int exp_next; bit exp_idle;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];
  vec_t t;
  int   checks = 0, failures = 0;
  int   hop_exp[3] = '{38, 39, 37};
  int   gap, idx, cyc, stall_rem;
  bit   seen, saw_valid, saw_idle, stop_sent, stall_bad, found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_rx_rst(input int bound, output int g, output bit s, output bit v, output bit idl);
    g = 0; s = 1'b0; v = 1'b0; idl = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (pkt_valid) v = 1'b1;
      if (!busy) idl = 1'b1;
      if (rx_rst) begin
        s = 1'b1;
        break;
      end
      g++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'h10 + i);
    vecs[0] = '{len:6,   crc:1'b1, stall_idx:-1, stall_cyc:0, stop_idx:-1, exp_ch:38, exp_n:8,  exp_crc:1'b1, exp_next:39, exp_idle:1'b0};
    vecs[1] = '{len:6,   crc:1'b1, stall_idx:3,  stall_cyc:5, stop_idx:-1, exp_ch:39, exp_n:8,  exp_crc:1'b1, exp_next:37, exp_idle:1'b0};
`ifdef BTLE_RX_SCAN_CRC_DROP_EN
    vecs[2] = '{len:3,   crc:1'b0, stall_idx:-1, stall_cyc:0, stop_idx:-1, exp_ch:37, exp_n:0,  exp_crc:1'b0, exp_next:38, exp_idle:1'b0};
`else
    vecs[2] = '{len:3,   crc:1'b0, stall_idx:-1, stall_cyc:0, stop_idx:-1, exp_ch:37, exp_n:5,  exp_crc:1'b0, exp_next:38, exp_idle:1'b0};
`endif
    vecs[3] = '{len:100, crc:1'b1, stall_idx:-1, stall_cyc:0, stop_idx:-1, exp_ch:38, exp_n:64, exp_crc:1'b1, exp_next:39, exp_idle:1'b0};
    vecs[4] = '{len:61,  crc:1'b1, stall_idx:-1, stall_cyc:0, stop_idx:-1, exp_ch:39, exp_n:63, exp_crc:1'b1, exp_next:37, exp_idle:1'b0};
    vecs[5] = '{len:6,   crc:1'b1, stall_idx:-1, stall_cyc:0, stop_idx:2,  exp_ch:37, exp_n:8,  exp_crc:1'b1, exp_next:37, exp_idle:1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_rst", rx_rst, 0);
    check("rst_channel", channel_number, 37);
    check("rst_access_addr", unique_bit_sequence, 32'h8E89BED6);
    check("rst_crc_init", crc_state_init_bit, 24'h555555);
    check("rst_mem_addr", rx_pdu_octet_mem_addr, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_pkt_channel", pkt_channel, 0);
    check("rst_pkt_crc_ok", pkt_crc_ok, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Dwell hopping 37 -> 38 -> 39 -> 37
    @(negedge clk);
    dwell_samples = 24'd16; iq_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_rx_rst", rx_rst, 1);
    check("start_channel", channel_number, 37);
    check("start_busy", busy, 1);
    for (int h = 0; h < 3; h++) begin
      wait_rx_rst(100, gap, seen, saw_valid, saw_idle);
      $display("hop %0d: channel=%0d listen_cycles=%0d", h, channel_number, gap);
      check("hop_seen", seen, 1);
      check("hop_dwell_cycles", gap, 16);
      check("hop_channel", channel_number, hop_exp[h]);
      check("hop_busy_held", saw_idle, 0);
    end

    // stop in LISTEN: IDLE next cycle with a one-cycle flush
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check("stop_listen_busy", busy, 0);
    check("stop_listen_rx_rst", rx_rst, 1);
    @(negedge clk);
    check("stop_listen_rx_rst_end", rx_rst, 0);

    // stop alone is ignored in IDLE
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_idle_busy", busy, 0);
    check("stop_idle_rx_rst", rx_rst, 0);

    // start and stop together: start wins; dwell 0 means no hopping from here on
    @(negedge clk); start = 1'b1; stop = 1'b1; dwell_samples = 24'd0;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 1);
    check("start_stop_rx_rst", rx_rst, 1);
    check("start_stop_channel", channel_number, 37);

    // Hit with no decode_end: timeout after TMO samples, no output
    @(negedge clk); rx_hit_flag = 1'b1;
    @(posedge clk); #1 rx_hit_flag = 1'b0;
    wait_rx_rst(TMO + 100, gap, seen, saw_valid, saw_idle);
    $display("timeout: channel=%0d receive_cycles=%0d", channel_number, gap);
    check("tmo_seen", seen, 1);
    check("tmo_cycles", gap, TMO);
    check("tmo_channel", channel_number, 38);
    check("tmo_no_valid", saw_valid, 0);

    // Packet table
    for (int v = 0; v < NV; v++) begin
      t = vecs[v];
      @(negedge clk);
      check("ch_at_hit", channel_number, t.exp_ch);
      rx_hit_flag = 1'b1;
      @(posedge clk); #1 rx_hit_flag = 1'b0;
      repeat (3) @(negedge clk);
      rx_decode_end = 1'b1; rx_crc_ok = t.crc; rx_payload_length = 7'(t.len);
      @(posedge clk); #1 rx_decode_end = 1'b0;
      idx = 0; cyc = 0; stall_rem = t.stall_cyc; stop_sent = 1'b0; stall_bad = 1'b0;
      while (idx < t.exp_n && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        stop = 1'b0;
        if (pkt_valid && idx == t.stall_idx && stall_rem > 0) begin
          pkt_ready = 1'b0;
          stall_rem--;
          if (32'(pkt_data) !== 32'(16 + idx) || 32'(rx_pdu_octet_mem_addr) !== 32'(idx)) stall_bad = 1'b1;
        end else begin
          pkt_ready = 1'b1;
        end
        if (pkt_valid && idx == t.stop_idx && !stop_sent) begin
          stop = 1'b1;
          stop_sent = 1'b1;
        end
        if (pkt_valid && pkt_ready) begin
          check("octet_data", pkt_data, 16 + idx);
          check("octet_last", pkt_last, (idx == t.exp_n - 1) ? 1 : 0);
          check("octet_channel", pkt_channel, t.exp_ch);
          check("octet_crc_ok", pkt_crc_ok, t.exp_crc);
          idx++;
        end
      end
      stop = 1'b0;
      $display("packet %0d: len=%0d crc=%0d channel=%0d octets=%0d cycles=%0d", v, t.len, t.crc, t.exp_ch, idx, cyc);
      check("octet_count", idx, t.exp_n);
      if (t.exp_n > 0) check("drain_cycles", cyc, 2 * t.exp_n + ((t.stall_idx >= 0) ? t.stall_cyc : 0));
      if (t.stall_idx >= 0) check("stall_hold", stall_bad, 0);
      if (t.exp_idle) begin
        @(negedge clk);
        check("pend_stop_busy", busy, 0);
        check("pend_stop_valid", pkt_valid, 0);
        check("pend_stop_channel", channel_number, t.exp_next);
      end else begin
        wait_rx_rst(50, gap, seen, saw_valid, saw_idle);
        check("post_hop_seen", seen, 1);
        check("post_hop_immediate", gap, 0);
        check("post_hop_channel", channel_number, t.exp_next);
        check("post_hop_no_extra", saw_valid, 0);
      end
    end

    // Reset in the middle of a packet
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rx_hit_flag = 1'b1;
    @(posedge clk); #1 rx_hit_flag = 1'b0;
    repeat (2) @(negedge clk);
    pkt_ready = 1'b0; rx_decode_end = 1'b1; rx_crc_ok = 1'b1; rx_payload_length = 7'd6;
    @(posedge clk); #1 rx_decode_end = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (pkt_valid) found = 1'b1;
    end
    check("midpkt_valid_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-packet: pkt_valid=%0d busy=%0d", pkt_valid, busy);
    check("midpkt_valid_drop", pkt_valid, 0);
    check("midpkt_busy", busy, 0);
    check("midpkt_addr", rx_pdu_octet_mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btle_rx_scan_ctrl.md
Name: btle_rx_scan_ctrl

Overview:
- Controller that sequences the multi-phase BLE receiver (`btle_rx`) through advertising-channel scanning (37→38→39→37…).
- Drives the receiver's configuration: access address, channel number, CRC init.
- Times the dwell on each channel, supervises packet reception, and drains the receiver's PDU octet memory into a valid/ready octet stream.
- Sits between the `btle_rx` instance and the host/packet sink.

Parameters:
- CHANNEL_NUMBER_BIT_WIDTH, 6, channel number width
- LEN_UNIQUE_BIT_SEQUENCE, 32, access-address width
- CRC_STATE_BIT_WIDTH, 24, CRC init width
- DWELL_BIT_WIDTH, 24, width of dwell sample counter
- RX_TIMEOUT_SAMPLES, 20000, max iq_valid samples from hit to decode_end

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin scanning (ignored unless IDLE)
- stop  in  1  pulse: end scanning
- dwell_samples  in  DWELL_BIT_WIDTH  iq_valid samples per channel; 0 = never hop
- iq_valid  in  1  same strobe fed to btle_rx; sample counting
- rx_hit_flag  in  1  btle_rx hit_flag pulse
- rx_decode_end  in  1  btle_rx decode_end pulse
- rx_crc_ok  in  1  btle_rx crc_ok (qualified by rx_decode_end)
- rx_payload_length  in  7  btle_rx payload_length
- rx_pdu_octet_mem_data  in  8  btle_rx pdu_octet_mem_data
- rx_pdu_octet_mem_addr  out  6  btle_rx pdu_octet_mem_addr
- rx_rst  out  1  one-cycle flush, ORed into btle_rx rst by integrator
- unique_bit_sequence  out  LEN_UNIQUE_BIT_SEQUENCE  to btle_rx
- channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  to btle_rx
- crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  to btle_rx
- pkt_data  out  8  PDU octet
- pkt_valid  out  1  octet valid
- pkt_ready  in  1  sink ready
- pkt_last  out  1  last octet of PDU
- pkt_channel  out  CHANNEL_NUMBER_BIT_WIDTH  channel of the packet
- pkt_crc_ok  out  1  CRC status of the packet
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE; rx_rst=0; channel_number=37; unique_bit_sequence=ADV_ACCESS_ADDR (32'h8E89BED6); crc_state_init_bit=ADV_CRC_INIT (24'h555555).
  - rx_pdu_octet_mem_addr=0; pkt_valid=0, pkt_last=0, pkt_data=0, pkt_channel=0, pkt_crc_ok=0; all counters 0.
- All outputs are registered.
- IDLE:
  - start → HOP with channel_number=37.
  - stop is ignored in IDLE.
- HOP (1 cycle): rx_rst=1; dwell counter cleared; → LISTEN.
- LISTEN:
  - Dwell counter increments on iq_valid.
  - rx_hit_flag → RECEIVE; timeout counter cleared.
  - Otherwise, when dwell_samples≠0 and iq_valid arrives with count==dwell_samples-1 → advance channel (39 wraps to 37) → HOP.
  - rx_hit_flag on the same cycle as dwell expiry: the hit wins.
- RECEIVE:
  - Timeout counter increments on iq_valid.
  - rx_decode_end → latch rx_crc_ok, rx_payload_length and the current channel.
    - Octet count N = min(rx_payload_length+2, 64).
    - → DRAIN; addr=0.
  - Timeout counter reaches RX_TIMEOUT_SAMPLES-1 with iq_valid → advance channel → HOP; no output.
  - rx_decode_end on the same cycle as timeout: decode_end wins.
- DRAIN (memory read latency is 1 cycle):
  - Present addr, wait 1 cycle, register the data into pkt_data.
  - Set pkt_valid; pkt_last=(addr==N-1); pkt_channel and pkt_crc_ok from the latched values.
  - Hold pkt_data/pkt_last/pkt_channel/pkt_crc_ok stable while pkt_valid && !pkt_ready.
  - On the handshake, addr increments.
  - After the last handshake → advance channel → HOP.
  - Throughput: 1 octet per 2 cycles minimum.
- stop:
  - In LISTEN or RECEIVE → next cycle IDLE, with rx_rst=1 for that one cycle.
  - In DRAIN → recorded as pending; the packet completes, then → IDLE instead of HOP.
  - stop while start is simultaneously asserted in IDLE: start wins.
- rst mid-packet: pkt_valid drops next cycle; no partial-packet completion.
- Configuration outputs (unique_bit_sequence, crc_state_init_bit) are constant ADV values; channel_number changes only on entry to HOP.

Optional Feature:
- Macro: BTLE_RX_SCAN_CRC_DROP_EN.
- Defined: a decode_end with rx_crc_ok=0 skips DRAIN → advance channel → HOP; no octets are emitted.
- Undefined: every decoded packet is drained; pkt_crc_ok reports the status.

Decomposition:
- Package btle_scan_pkg:
  - ADV_ACCESS_ADDR, ADV_CRC_INIT.
  - ADV_CH_FIRST=37, ADV_CH_LAST=39.
  - MAX_PDU_OCTETS=64.
  - State enum IDLE/HOP/LISTEN/RECEIVE/DRAIN.
- One natural sub-module, btle_pdu_drain: address counter plus the 1-cycle-latency memory-to-valid/ready stage, with start/N/done handshake to the FSM.

Test Plan:
- start, dwell_samples=16, iq_valid every cycle, no hits → channel 37 for 16 samples, 1-cycle rx_rst, then 38, 39, 37; busy=1 throughout.
- Hit on ch38, decode_end crc_ok=1, payload_length=6, memory holds 0x10..0x17 → 8 octets 0x10..0x17, pkt_last on 0x17, pkt_channel=38, pkt_crc_ok=1; then HOP to 39.
- Same packet with pkt_ready low for 5 cycles at octet 3 → pkt_data=0x13 stable, addr does not advance, all 8 octets delivered in order.
- decode_end crc_ok=0, payload_length=3:
  - Macro undefined → 5 octets, pkt_crc_ok=0.
  - Macro defined → zero octets, direct HOP.
- payload_length=100 → exactly 64 octets, pkt_last at addr 63; hit without decode_end for RX_TIMEOUT_SAMPLES → rx_rst, next channel, no pkt_valid.
- stop during LISTEN → IDLE next cycle with rx_rst pulse; stop during DRAIN at octet 2 of 8 → all 8 delivered, then IDLE, busy=0.
